// File: rtl/rtc_reg_arbiter_if.sv
// Request/ack bundle between the RTC requesters, the arbiter and the 16x8 register file.
// master = requesters plus register-file model, slave = arbiter.
interface rtc_reg_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              tk_req;
  logic [ADDR_W-1:0] tk_addr;
  logic [DATA_W-1:0] tk_wdata;
  logic              tk_ack;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_burst;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  logic              lock_err;

  modport master (
    output tk_req, tk_addr, tk_wdata, host_req, host_we, host_addr, host_wdata,
           host_burst, reg_rdata,
    input  tk_ack, host_ack, host_rdata, reg_addr, reg_wdata, reg_we, reg_re,
           lock_err
  );

  modport slave (
    input  tk_req, tk_addr, tk_wdata, host_req, host_we, host_addr, host_wdata,
           host_burst, reg_rdata,
    output tk_ack, host_ack, host_rdata, reg_addr, reg_wdata, reg_we, reg_re,
           lock_err
  );
endinterface

// File: rtl/rtc_reg_arbiter.sv
// Round-robin arbiter between RTC timekeeping write-back and the I2C host; write ack 1 cycle, read ack 3 cycles after grant.
// Requesters hold req until ack; host_burst defers TK writes until LOCK_TIMEOUT blocked cycles force a grant (lock_err).
module rtc_reg_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  rtc_reg_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RD_DONE} state_t;
  typedef enum logic {GNT_TK, GNT_HOST} grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              tk_ack_q, tk_ack_d;
  logic              host_ack_q, host_ack_d;
  logic              lock_err_q, lock_err_d;

  logic tk_elig, host_elig, grant_tk, grant_host;

  // TK is held off during a host burst unless it has waited the full timeout.
  always_comb begin
    tk_elig    = bus.tk_req && (!bus.host_burst || (lock_cnt_q == LOCK_MAX));
    host_elig  = bus.host_req;
    grant_tk   = 1'b0;
    grant_host = 1'b0;
    if (state_q == IDLE) begin
      if (tk_elig && (!host_elig || (last_grant_q == GNT_HOST))) begin
        grant_tk = 1'b1;
      end else if (host_elig) begin
        grant_host = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    host_rdata_d = host_rdata_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    tk_ack_d     = 1'b0;
    host_ack_d   = 1'b0;
    lock_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_tk) begin
          state_d      = WR;
          last_grant_d = GNT_TK;
          reg_addr_d   = bus.tk_addr;
          reg_wdata_d  = bus.tk_wdata;
          reg_we_d     = 1'b1;
          tk_ack_d     = 1'b1;
          lock_err_d   = bus.host_burst;
        end else if (grant_host) begin
          last_grant_d = GNT_HOST;
          reg_addr_d   = bus.host_addr;
          if (bus.host_we) begin
            state_d     = WR;
            reg_wdata_d = bus.host_wdata;
            reg_we_d    = 1'b1;
            host_ack_d  = 1'b1;
          end else begin
            state_d  = RD;
            reg_re_d = 1'b1;
          end
        end
      end
      WR:      state_d = IDLE;
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        state_d      = RD_DONE;
        host_rdata_d = bus.reg_rdata;
        host_ack_d   = 1'b1;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!bus.tk_req || !bus.host_burst || grant_tk) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_TK;
      lock_cnt_q   <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      host_rdata_q <= '0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      tk_ack_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      host_rdata_q <= host_rdata_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      tk_ack_q     <= tk_ack_d;
      host_ack_q   <= host_ack_d;
      lock_err_q   <= lock_err_d;
    end
  end

  assign bus.tk_ack     = tk_ack_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.reg_we     = reg_we_q;
  assign bus.reg_re     = reg_re_q;
  assign bus.lock_err   = lock_err_q;

endmodule
